vga_timing_gen: RTL

Parametrised successor to the fixed 640x350 sync generator. Produces hsync/vsync, data-enable, pixel coordinates and frame/line strobes for any VGA-class mode. Timing is runtime-reprogrammable through a valid/ready config port, and a new config takes effect only at a frame boundary. It sits between the pixel-clock-enable source and the VRAM read / RGB output logic of the text display pipeline.

---
 rtl/vga_timing_pkg.sv | 58 +++++
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/vga_axis_cnt.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared types for the VGA timing generator.
//                - vga_timing_t : packed timing record, first field in the MSBs
//                - vga_region_e : per-axis region (ACTIVE, FP, SYNC, BP)
//                - default 640x350 and 640x480 timing constants
//                - vga_fields_ok: config validation
//  Revision    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    localparam int VGA_CW = 11;

    typedef struct packed {
        logic [VGA_CW-1:0] h_active;
        logic [VGA_CW-1:0] h_fp;
        logic [VGA_CW-1:0] h_sync;
        logic [VGA_CW-1:0] h_bp;
        logic [VGA_CW-1:0] v_active;
        logic [VGA_CW-1:0] v_fp;
        logic [VGA_CW-1:0] v_sync;
        logic [VGA_CW-1:0] v_bp;
        logic              hs_pol;
        logic              vs_pol;
    } vga_timing_t;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } vga_region_e;

    localparam vga_timing_t VGA_640X350 = '{11'd640, 11'd16, 11'd96, 11'd48,
                                            11'd350, 11'd37, 11'd2,  11'd60,
                                            1'b1, 1'b0};
    localparam vga_timing_t VGA_640X480 = '{11'd640, 11'd16, 11'd96, 11'd48,
                                            11'd480, 11'd10, 11'd2,  11'd33,
                                            1'b0, 1'b0};

    // Every width field must be non-zero and each axis total must fit in cw bits.
    function automatic logic vga_fields_ok(
        input logic [31:0] ha, hf, hs, hb,
        input logic [31:0] va, vf, vs, vb,
        input int          cw
    );
        logic [31:0] ht;
        logic [31:0] vt;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        return (ha != 0) && (hf != 0) && (hs != 0) && (hb != 0) &&
               (va != 0) && (vf != 0) && (vs != 0) && (vb != 0) &&
               (ht < (32'd1 << cw)) && (vt < (32'd1 << cw));
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Runtime timing configuration port (valid/ready plus reject
//                pulse). cfg_timing packs the vga_timing_t field order:
//                h_active (MSBs) .. v_bp, hs_pol, vs_pol (LSB).
//                master : config source     slave : timing generator
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [8*CW+1:0]   cfg_timing;
    logic              cfg_err;

    modport master (output cfg_valid, output cfg_timing,
                    input  cfg_ready, input  cfg_err);
    modport slave  (input  cfg_valid, input  cfg_timing,
                    output cfg_ready, output cfg_err);
endinterface
`default_nettype wire

// File: rtl/vga_axis_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_cnt
//  Description : One timing axis: enabled wrap counter with terminal detect
//                and active/front-porch/sync/back-porch region decode.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                i_en           advance the counter this cycle
//                i_act..i_bp    region widths of the live timing
//                o_cnt          current count
//                o_term         count is at (or beyond) the last position
//                o_region       region of the current count
//  Revision    : 1.0  initial release
// ============================================================================
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int CW = 11
)(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_en,
    input  wire logic [CW-1:0] i_act,
    input  wire logic [CW-1:0] i_fp,
    input  wire logic [CW-1:0] i_sync,
    input  wire logic [CW-1:0] i_bp,
    output logic      [CW-1:0] o_cnt,
    output logic               o_term,
    output vga_region_e        o_region
);
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_sync_start;
    logic [CW-1:0] w_bp_start;
    logic [CW-1:0] w_total;

    assign w_sync_start = i_act + i_fp;
    assign w_bp_start   = w_sync_start + i_sync;
    assign w_total      = w_bp_start + i_bp;

    // >= so a count left beyond a shrunken total still wraps immediately.
    assign o_term = (r_cnt >= (w_total - CW'(1)));
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_term ? '0 : r_cnt + CW'(1);
        end
    end

    always_comb begin
        o_region = BP;
        if (r_cnt < i_act) begin
            o_region = ACTIVE;
        end else if (r_cnt < w_sync_start) begin
            o_region = FP;
        end else if (r_cnt < w_bp_start) begin
            o_region = SYNC;
        end
    end
endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Programmable VGA sync generator. Produces hsync/vsync with
//                polarity, data enable, pixel coordinates and line/frame
//                strobes. A new timing offered on cfg is held in a shadow
//                slot and becomes live only at the end of a frame.
//  Ports       : clk, rst             clock, synchronous active-high reset
//                pix_en               pixel enable; timing advances when 1
//                cfg (slave)          cfg_valid/cfg_ready/cfg_timing/cfg_err
//                o_hsync, o_vsync     syncs with polarity applied
//                o_de, o_x, o_y       active video flag and coordinates
//                o_line_start         pulse at h=0
//                o_frame_start        pulse at h=0, v=0
//  Option      : VGA_TIMING_CELL_EN adds o_col, o_row, o_glyph_row and
//                o_cell_fetch for the 8x8 character cell pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW       = VGA_CW,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 350,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 60,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 0
)(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        pix_en,
    vga_timing_gen_if.slave  cfg,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [CW-1:0]    o_x,
    output logic [CW-1:0]    o_y,
    output logic             o_line_start,
    output logic             o_frame_start
`ifdef VGA_TIMING_CELL_EN
    ,
    output logic [CW-4:0]    o_col,
    output logic [CW-4:0]    o_row,
    output logic [2:0]       o_glyph_row,
    output logic             o_cell_fetch
`endif
);
    localparam int c_TW = 8*CW + 2;
    localparam logic [c_TW-1:0] c_DEFAULT = {
        CW'(H_ACTIVE), CW'(H_FP), CW'(H_SYNC), CW'(H_BP),
        CW'(V_ACTIVE), CW'(V_FP), CW'(V_SYNC), CW'(V_BP),
        1'(HS_POL), 1'(VS_POL)};

    logic [c_TW-1:0] r_live;
    logic [c_TW-1:0] r_shadow;
    logic            r_shadow_full;
    logic            r_err_pend;
    logic            r_cfg_err;

    logic [CW-1:0]   w_h_cnt, w_v_cnt;
    logic            w_h_term, w_v_term;
    vga_region_e     w_h_rgn, w_v_rgn;
    logic            w_de, w_apply, w_xfer, w_cfg_ok, w_reject;

    // ---------------------------------------------------------------- axes
    vga_axis_cnt #(.CW(CW)) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .i_en     (pix_en),
        .i_act    (r_live[8*CW+1 -: CW]),
        .i_fp     (r_live[7*CW+1 -: CW]),
        .i_sync   (r_live[6*CW+1 -: CW]),
        .i_bp     (r_live[5*CW+1 -: CW]),
        .o_cnt    (w_h_cnt),
        .o_term   (w_h_term),
        .o_region (w_h_rgn)
    );

    vga_axis_cnt #(.CW(CW)) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .i_en     (pix_en & w_h_term),
        .i_act    (r_live[4*CW+1 -: CW]),
        .i_fp     (r_live[3*CW+1 -: CW]),
        .i_sync   (r_live[2*CW+1 -: CW]),
        .i_bp     (r_live[CW+1 -: CW]),
        .o_cnt    (w_v_cnt),
        .o_term   (w_v_term),
        .o_region (w_v_rgn)
    );

    // ------------------------------------------------------------- config
    assign w_cfg_ok = vga_fields_ok(
        32'(cfg.cfg_timing[8*CW+1 -: CW]), 32'(cfg.cfg_timing[7*CW+1 -: CW]),
        32'(cfg.cfg_timing[6*CW+1 -: CW]), 32'(cfg.cfg_timing[5*CW+1 -: CW]),
        32'(cfg.cfg_timing[4*CW+1 -: CW]), 32'(cfg.cfg_timing[3*CW+1 -: CW]),
        32'(cfg.cfg_timing[2*CW+1 -: CW]), 32'(cfg.cfg_timing[CW+1 -: CW]),
        CW);

    assign w_xfer   = cfg.cfg_valid & ~r_shadow_full;
    assign w_reject = w_xfer & ~w_cfg_ok;
    // Apply and accept are exclusive: apply needs a full slot, accept an empty one.
    assign w_apply  = pix_en & w_h_term & w_v_term & r_shadow_full;

    assign cfg.cfg_ready = ~r_shadow_full;
    assign cfg.cfg_err   = r_cfg_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_live        <= c_DEFAULT;
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_err_pend    <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_live        <= r_shadow;
                r_shadow_full <= 1'b0;
            end else if (w_xfer && w_cfg_ok) begin
                r_shadow      <= cfg.cfg_timing;
                r_shadow_full <= 1'b1;
            end
            // A rejection seen while pix_en=0 is held until the next pixel
            // cycle so the error pulse stays aligned with the other strobes.
            if (pix_en) begin
                r_cfg_err  <= r_err_pend | w_reject;
                r_err_pend <= 1'b0;
            end else begin
                r_cfg_err  <= 1'b0;
                r_err_pend <= r_err_pend | w_reject;
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign w_de = (w_h_rgn == ACTIVE) && (w_v_rgn == ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_hsync       <= ~c_DEFAULT[1];
            o_vsync       <= ~c_DEFAULT[0];
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (pix_en) begin
            o_hsync       <= (w_h_rgn == SYNC) ? r_live[1] : ~r_live[1];
            o_vsync       <= (w_v_rgn == SYNC) ? r_live[0] : ~r_live[0];
            o_de          <= w_de;
            o_x           <= w_de ? w_h_cnt : '0;
            o_y           <= w_de ? w_v_cnt : '0;
            o_line_start  <= (w_h_cnt == '0);
            o_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
        end else begin
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_CELL_EN
    // Fetch at pixel 4 of each cell gives VRAM half a cell of lead time.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_col        <= '0;
            o_row        <= '0;
            o_glyph_row  <= '0;
            o_cell_fetch <= 1'b0;
        end else if (pix_en) begin
            o_col        <= w_de ? w_h_cnt[CW-1:3] : '0;
            o_row        <= w_de ? w_v_cnt[CW-1:3] : '0;
            o_glyph_row  <= w_de ? w_v_cnt[2:0]    : '0;
            o_cell_fetch <= w_de && (w_h_cnt[2:0] == 3'd4);
        end else begin
            o_cell_fetch <= 1'b0;
        end
    end
`endif
endmodule
`default_nettype wire
